// File: rtl/instr_sequencer_pkg.sv
// Shared CPU definitions: opcodes, microsteps, sequencer states and the control word.
package cpu_pkg;

   localparam int unsigned OPCODE_W = 4;
   localparam int unsigned STEP_W   = 3;

   typedef enum logic [OPCODE_W-1:0] {
      OP_NOP = 4'h0,
      OP_LDA = 4'h1,
      OP_ADD = 4'h2,
      OP_SUB = 4'h3,
      OP_STA = 4'h4,
      OP_LDI = 4'h5,
      OP_JMP = 4'h6,
      OP_JC  = 4'h7,
      OP_JZ  = 4'h8,
      OP_OUT = 4'hE,
      OP_HLT = 4'hF
   } opcode_e;

   typedef enum logic [STEP_W-1:0] {T0, T1, T2, T3, T4} step_e;

   typedef enum logic [1:0] {ST_FETCH, ST_EXEC, ST_HALT} state_e;

   typedef struct packed {
      logic pc_out;
      logic i_out;
      logic ram_out;
      logic a_out;
      logic alu_out;
      logic mar_in;
      logic i_in;
      logic ram_in;
      logic a_in;
      logic b_in;
      logic out_in;
      logic pc_inc;
      logic pc_jump;
      logic alu_sub;
      logic flags_in;
      logic halt;
   } ctrl_t;

   localparam ctrl_t CTRL_NONE = '0;
   localparam ctrl_t CTRL_T0   = '{pc_out: 1'b1, mar_in: 1'b1, default: 1'b0};
   localparam ctrl_t CTRL_HALT = '{halt: 1'b1, default: 1'b0};

   // Last EXEC step that can carry a non-empty word for this opcode.
   function automatic step_e exec_last_step(opcode_e op);
      case (op)
         OP_LDA, OP_STA: return T3;
         OP_ADD, OP_SUB: return T4;
         default:        return T2;
      endcase
   endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Sequencer control bus: step/instruction/flag inputs and the decoded control lines.
interface instr_sequencer_if;
   logic       step_en;
   logic [7:0] instruction;
   logic       carry_flag;
   logic       zero_flag;
   logic       pc_out, i_out, ram_out, a_out, alu_out;
   logic       mar_in, i_in, ram_in, a_in, b_in, out_in;
   logic       pc_inc, pc_jump, alu_sub, flags_in, halt;
   logic [2:0] step;

   modport slave (
      input  step_en, instruction, carry_flag, zero_flag,
      output pc_out, i_out, ram_out, a_out, alu_out,
      output mar_in, i_in, ram_in, a_in, b_in, out_in,
      output pc_inc, pc_jump, alu_sub, flags_in, halt, step
   );

   modport master (
      output step_en, instruction, carry_flag, zero_flag,
      input  pc_out, i_out, ram_out, a_out, alu_out,
      input  mar_in, i_in, ram_in, a_in, b_in, out_in,
      input  pc_inc, pc_jump, alu_sub, flags_in, halt, step
   );
endinterface

// File: rtl/instr_sequencer_rom.sv
// Combinational microcode: (opcode, step, carry, zero) -> control word.
import cpu_pkg::*;

module microcode_rom (
   input  opcode_e opcode_i,
   input  step_e   step_i,
   input  logic    carry_i,
   input  logic    zero_i,
   output ctrl_t   ctrl_o
);
   always_comb begin
      ctrl_o = CTRL_NONE;
      case (step_i)
         T0: ctrl_o = CTRL_T0;
         T1: begin
            ctrl_o.ram_out = 1'b1;
            ctrl_o.i_in    = 1'b1;
            ctrl_o.pc_inc  = 1'b1;
         end
         T2: case (opcode_i)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
               ctrl_o.i_out  = 1'b1;
               ctrl_o.mar_in = 1'b1;
            end
            OP_LDI: begin
               ctrl_o.i_out = 1'b1;
               ctrl_o.a_in  = 1'b1;
            end
            OP_JMP: begin
               ctrl_o.i_out   = 1'b1;
               ctrl_o.pc_jump = 1'b1;
            end
            // Conditional jumps decode the flags only here, in T2.
            OP_JC: begin
               ctrl_o.i_out   = carry_i;
               ctrl_o.pc_jump = carry_i;
            end
            OP_JZ: begin
               ctrl_o.i_out   = zero_i;
               ctrl_o.pc_jump = zero_i;
            end
            OP_OUT: begin
               ctrl_o.a_out  = 1'b1;
               ctrl_o.out_in = 1'b1;
            end
            OP_HLT:  ctrl_o.halt = 1'b1;
            default: ;
         endcase
         T3: case (opcode_i)
            OP_LDA: begin
               ctrl_o.ram_out = 1'b1;
               ctrl_o.a_in    = 1'b1;
            end
            OP_ADD, OP_SUB: begin
               ctrl_o.ram_out = 1'b1;
               ctrl_o.b_in    = 1'b1;
            end
            OP_STA: begin
               ctrl_o.a_out  = 1'b1;
               ctrl_o.ram_in = 1'b1;
            end
            default: ;
         endcase
         T4: if (opcode_i == OP_ADD || opcode_i == OP_SUB) begin
            ctrl_o.alu_out  = 1'b1;
            ctrl_o.a_in     = 1'b1;
            ctrl_o.flags_in = 1'b1;
            ctrl_o.alu_sub  = (opcode_i == OP_SUB);
         end
         default: ;
      endcase
   end
endmodule

// File: rtl/instr_sequencer.sv
// Microstep sequencer: FETCH/EXEC/HALT state and step counter around the microcode ROM.
// Define SEQ_EARLY_END_EN to return to T0 as soon as the remaining EXEC steps are empty.
import cpu_pkg::*;

module instr_sequencer (
   input logic              clk,
   input logic              rst_n,
   instr_sequencer_if.slave bus
);
   state_e     state_q, state_d;
   step_e      step_q, step_d, last_step;
   opcode_e    opcode;
   ctrl_t      rom_ctrl, ctrl;
   logic [3:0] operand_unused;

   assign opcode         = opcode_e'(bus.instruction[7:4]);
   assign operand_unused = bus.instruction[3:0];

`ifdef SEQ_EARLY_END_EN
   assign last_step = exec_last_step(opcode);
`else
   assign last_step = T4;
`endif

   microcode_rom u_rom (
      .opcode_i (opcode),
      .step_i   (step_q),
      .carry_i  (bus.carry_flag),
      .zero_i   (bus.zero_flag),
      .ctrl_o   (rom_ctrl)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_FETCH;
         step_q  <= T0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
      end
   end

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      if (bus.step_en) begin
         case (state_q)
            ST_FETCH:
               if (step_q == T0) begin
                  step_d = T1;
               end else begin
                  state_d = ST_EXEC;
                  step_d  = T2;
               end
            // The opcode is not latched, so a live change can leave us past last_step.
            ST_EXEC:
               if (step_q == T2 && opcode == OP_HLT) begin
                  state_d = ST_HALT;
               end else if (step_q >= last_step || step_q == T4) begin
                  state_d = ST_FETCH;
                  step_d  = T0;
               end else begin
                  step_d = step_e'(step_q + 3'd1);
               end
            default: ;
         endcase
      end
   end

   always_comb begin
      ctrl = rom_ctrl;
      if (!rst_n)                  ctrl = CTRL_T0;
      else if (state_q == ST_HALT) ctrl = CTRL_HALT;
   end

   assign bus.pc_out   = ctrl.pc_out;
   assign bus.i_out    = ctrl.i_out;
   assign bus.ram_out  = ctrl.ram_out;
   assign bus.a_out    = ctrl.a_out;
   assign bus.alu_out  = ctrl.alu_out;
   assign bus.mar_in   = ctrl.mar_in;
   assign bus.i_in     = ctrl.i_in;
   assign bus.ram_in   = ctrl.ram_in;
   assign bus.a_in     = ctrl.a_in;
   assign bus.b_in     = ctrl.b_in;
   assign bus.out_in   = ctrl.out_in;
   assign bus.pc_inc   = ctrl.pc_inc;
   assign bus.pc_jump  = ctrl.pc_jump;
   assign bus.alu_sub  = ctrl.alu_sub;
   assign bus.flags_in = ctrl.flags_in;
   assign bus.halt     = ctrl.halt;
   assign bus.step     = step_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: vector table, directed corner sequences, random run vs. model.
module tb_instr_sequencer;
   localparam logic [15:0] W_PC_OUT = 16'h8000, W_I_OUT = 16'h4000, W_RAM_OUT = 16'h2000,
                           W_A_OUT = 16'h1000, W_ALU_OUT = 16'h0800, W_MAR_IN = 16'h0400,
                           W_I_IN = 16'h0200, W_RAM_IN = 16'h0100, W_A_IN = 16'h0080,
                           W_B_IN = 16'h0040, W_OUT_IN = 16'h0020, W_PC_INC = 16'h0010,
                           W_PC_JUMP = 16'h0008, W_ALU_SUB = 16'h0004, W_FLAGS_IN = 16'h0002,
                           W_HALT = 16'h0001;
   localparam logic [15:0] W_T0 = W_PC_OUT | W_MAR_IN;
   localparam logic [15:0] W_T1 = W_RAM_OUT | W_I_IN | W_PC_INC;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   instr_sequencer_if sif();
   instr_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(sif));

   int total = 0;
   int bad   = 0;

   typedef struct {
      bit         rst;
      bit         en;
      logic [7:0] ins;
      bit         c;
      bit         z;
      bit         chk_st;
      logic [2:0] st;
      logic [15:0] w;
   } vec_t;
   vec_t vecs[$];

`ifdef SEQ_EARLY_END_EN
   int nop_seq[6] = '{0, 1, 2, 0, 1, 2};
`else
   int nop_seq[6] = '{0, 1, 2, 3, 4, 0};
`endif

   // Reference model: instruction = two fetch words then its EXEC words (T2..T4).
   logic [15:0] ucode [16][3];
   int k;
   bit halted;

   function automatic int ilen(logic [3:0] op);
`ifdef SEQ_EARLY_END_EN
      int n = 3;
      for (int j = 0; j < 3; j++) if (ucode[op][j] != 16'h0) n = j + 3;
      return n;
`else
      return 5;
`endif
   endfunction

   function automatic logic [15:0] m_word(bit r, logic [3:0] op, bit c, bit z);
      logic [15:0] w;
      if (!r) return W_T0;
      if (halted) return W_HALT;
      if (k == 0) return W_T0;
      if (k == 1) return W_T1;
      w = ucode[op][k-2];
      if ((op == 4'h7 && !c) || (op == 4'h8 && !z)) w = 16'h0;
      return w;
   endfunction

   task automatic m_clock(bit r, bit e, logic [3:0] op);
      if (!r) begin
         k = 0;
         halted = 0;
      end else if (e && !halted) begin
         if (k == 2 && op == 4'hF) halted = 1;
         else if (k + 1 >= ilen(op)) k = 0;
         else k++;
      end
   endtask

   function automatic logic [15:0] act_word();
      return {sif.pc_out, sif.i_out, sif.ram_out, sif.a_out, sif.alu_out, sif.mar_in,
              sif.i_in, sif.ram_in, sif.a_in, sif.b_in, sif.out_in, sif.pc_inc,
              sif.pc_jump, sif.alu_sub, sif.flags_in, sif.halt};
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input bit r, input bit e, input logic [7:0] ins, input bit c, input bit z);
      rst_n           = r;
      sif.step_en     = e;
      sif.instruction = ins;
      sif.carry_flag  = c;
      sif.zero_flag   = z;
      #1;
   endtask

   task automatic tick();
      m_clock(rst_n, sif.step_en, sif.instruction[7:4]);
      @(negedge clk);
   endtask

   task automatic do_reset();
      drive(0, 0, 8'h00, 0, 0);
      tick();
   endtask

   function automatic vec_t mk(bit r, bit e, logic [7:0] ins, bit c, bit z, bit cs,
                               logic [2:0] st, logic [15:0] w);
      vec_t v;
      v.rst = r; v.en = e; v.ins = ins; v.c = c; v.z = z; v.chk_st = cs; v.st = st; v.w = w;
      return v;
   endfunction

   initial begin
      logic [15:0] a;
      bit r, e, c, z;
      logic [7:0] ins;

      for (int o = 0; o < 16; o++) for (int j = 0; j < 3; j++) ucode[o][j] = 16'h0;
      ucode[1][0] = W_I_OUT | W_MAR_IN;  ucode[1][1] = W_RAM_OUT | W_A_IN;
      ucode[2][0] = W_I_OUT | W_MAR_IN;  ucode[2][1] = W_RAM_OUT | W_B_IN;
      ucode[2][2] = W_ALU_OUT | W_A_IN | W_FLAGS_IN;
      ucode[3][0] = W_I_OUT | W_MAR_IN;  ucode[3][1] = W_RAM_OUT | W_B_IN;
      ucode[3][2] = W_ALU_OUT | W_A_IN | W_FLAGS_IN | W_ALU_SUB;
      ucode[4][0] = W_I_OUT | W_MAR_IN;  ucode[4][1] = W_A_OUT | W_RAM_IN;
      ucode[5][0] = W_I_OUT | W_A_IN;
      ucode[6][0] = W_I_OUT | W_PC_JUMP;
      ucode[7][0] = W_I_OUT | W_PC_JUMP;
      ucode[8][0] = W_I_OUT | W_PC_JUMP;
      ucode[14][0] = W_A_OUT | W_OUT_IN;
      ucode[15][0] = W_HALT;
      k = 0;
      halted = 0;

      // ADD, SUB (flags toggled outside T2), STA with step_en alternating, then reset.
      vecs.push_back(mk(1, 1, 8'h2A, 0, 0, 1, 0, W_T0));
      vecs.push_back(mk(1, 1, 8'h2A, 1, 1, 1, 1, W_T1));
      vecs.push_back(mk(1, 1, 8'h2A, 0, 0, 1, 2, W_I_OUT | W_MAR_IN));
      vecs.push_back(mk(1, 1, 8'h2A, 1, 0, 1, 3, W_RAM_OUT | W_B_IN));
      vecs.push_back(mk(1, 1, 8'h2A, 1, 1, 1, 4, W_ALU_OUT | W_A_IN | W_FLAGS_IN));
      vecs.push_back(mk(1, 1, 8'h3A, 0, 0, 1, 0, W_T0));
      vecs.push_back(mk(1, 1, 8'h3A, 0, 0, 1, 1, W_T1));
      vecs.push_back(mk(1, 1, 8'h3A, 0, 0, 1, 2, W_I_OUT | W_MAR_IN));
      vecs.push_back(mk(1, 1, 8'h3A, 0, 1, 1, 3, W_RAM_OUT | W_B_IN));
      vecs.push_back(mk(1, 1, 8'h3A, 0, 0, 1, 4, W_ALU_OUT | W_A_IN | W_FLAGS_IN | W_ALU_SUB));
      vecs.push_back(mk(1, 1, 8'h4C, 0, 0, 1, 0, W_T0));
      vecs.push_back(mk(1, 0, 8'h4C, 0, 0, 1, 1, W_T1));
      vecs.push_back(mk(1, 1, 8'h4C, 0, 0, 1, 1, W_T1));
      vecs.push_back(mk(1, 0, 8'h4C, 0, 0, 1, 2, W_I_OUT | W_MAR_IN));
      vecs.push_back(mk(1, 1, 8'h4C, 0, 0, 1, 2, W_I_OUT | W_MAR_IN));
      vecs.push_back(mk(1, 0, 8'h4C, 0, 0, 1, 3, W_A_OUT | W_RAM_IN));
      vecs.push_back(mk(1, 1, 8'h4C, 0, 0, 1, 3, W_A_OUT | W_RAM_IN));
      vecs.push_back(mk(0, 1, 8'h4C, 0, 0, 0, 0, W_T0));
      vecs.push_back(mk(1, 0, 8'h4C, 0, 0, 1, 0, W_T0));

      do_reset();
      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].en, vecs[i].ins, vecs[i].c, vecs[i].z);
         check($sformatf("vec%0d word", i), act_word(), vecs[i].w);
         if (vecs[i].chk_st) check($sformatf("vec%0d step", i), {13'h0, sif.step}, {13'h0, vecs[i].st});
         tick();
      end

      // NOP step sequence
      do_reset();
      for (int i = 0; i < 6; i++) begin
         drive(1, 1, 8'h00, 0, 0);
         check($sformatf("nop step%0d", i), {13'h0, sif.step}, nop_seq[i][15:0]);
         if (i == 0) check("nop T0 word", act_word(), W_T0);
         if (i == 1) check("nop T1 word", act_word(), W_T1);
         tick();
      end

      // JC / JZ decide in T2 from the live flags
      do_reset();
      drive(1, 1, 8'h73, 0, 0); tick();
      drive(1, 1, 8'h73, 0, 0); tick();
      drive(1, 0, 8'h73, 0, 0); check("jc untaken", act_word(), 16'h0);
      drive(1, 0, 8'h73, 1, 0); check("jc taken", act_word(), W_I_OUT | W_PC_JUMP);
      drive(1, 0, 8'h83, 1, 0); check("jz untaken", act_word(), 16'h0);
      drive(1, 0, 8'h83, 0, 1); check("jz taken", act_word(), W_I_OUT | W_PC_JUMP);

      // HLT sticks until reset
      do_reset();
      drive(1, 1, 8'hF0, 0, 0); tick();
      drive(1, 1, 8'hF0, 0, 0); tick();
      drive(1, 1, 8'hF0, 0, 0);
      check("hlt T2 word", act_word(), W_HALT);
      tick();
      for (int i = 0; i < 10; i++) begin
         drive(1, 1, 8'($urandom), 1'($urandom), 1'($urandom));
         check($sformatf("halted word%0d", i), act_word(), W_HALT);
         check($sformatf("halted step%0d", i), {13'h0, sif.step}, 16'd2);
         tick();
      end
      drive(0, 1, 8'hF0, 0, 0);
      check("halt in reset word", act_word(), W_T0);
      tick();
      drive(1, 0, 8'hF0, 0, 0);
      check("halt exit word", act_word(), W_T0);
      check("halt exit step", {13'h0, sif.step}, 16'd0);

      // Reset in T3 of LDA abandons it
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 8'h15, 0, 0); tick();
      end
      drive(1, 1, 8'h15, 0, 0);
      check("lda T3 word", act_word(), W_RAM_OUT | W_A_IN);
      check("lda T3 step", {13'h0, sif.step}, 16'd3);
      drive(0, 1, 8'h15, 0, 0); tick();
      drive(1, 1, 8'h15, 0, 0);
      check("lda abort step", {13'h0, sif.step}, 16'd0);
      check("lda abort word", act_word(), W_T0);
      tick();

      // Random run against the model
      do_reset();
      for (int i = 0; i < 10000; i++) begin
         r   = ($urandom_range(0, 199) != 0);
         e   = ($urandom_range(0, 3) != 0);
         ins = 8'($urandom);
         c   = 1'($urandom);
         z   = 1'($urandom);
         drive(r, e, ins, c, z);
         a = act_word();
         check($sformatf("rand%0d word", i), a, m_word(r, ins[7:4], c, z));
         if (r) check($sformatf("rand%0d step", i), {13'h0, sif.step},
                      halted ? 16'd2 : k[15:0]);
         check($sformatf("rand%0d onehot", i), {15'h0, $countones(a[15:11]) <= 1}, 16'd1);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 clk  input  1  CPU clock (cpu_clk); all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
REQ-004 step_en  input  1  advance enable; when low, step counter and state hold, outputs stay stable.
REQ-005 instruction  input  8  instruction register value; [7:4] opcode, [3:0] operand.
REQ-006 carry_flag / zero_flag  input  1 each  latched ALU flags.
REQ-007 bus drivers  output  1 each: pc_out, i_out, ram_out, a_out, alu_out.
REQ-008 bus loaders  output  1 each: mar_in, i_in, ram_in, a_in, b_in, out_in.
REQ-009 other controls  output  1 each: pc_inc, pc_jump, alu_sub, flags_in, halt.
REQ-010 step  output  3  current microstep T0..T4.

Function
REQ-011 States: FETCH (T0-T1), EXEC (T2-T4), HALT; step counter registered, control outputs combinational from step, opcode and flags.
REQ-012 T0: pc_out, mar_in. T1: ram_out, i_in, pc_inc.
REQ-013 EXEC per opcode, other controls 0:
- LDA 0x1: T2 i_out,mar_in; T3 ram_out,a_in.
- ADD 0x2: T2 i_out,mar_in; T3 ram_out,b_in; T4 alu_out,a_in,flags_in.
- SUB 0x3: as ADD, plus alu_sub in T4.
- STA 0x4: T2 i_out,mar_in; T3 a_out,ram_in.
- LDI 0x5: T2 i_out,a_in.
- JMP 0x6: T2 i_out,pc_jump.
- JC 0x7 / JZ 0x8: T2 i_out,pc_jump only if carry_flag / zero_flag is 1; otherwise T2 empty.
- OUT 0xE: T2 a_out,out_in. HLT 0xF: T2 halt.
- NOP 0x0 and undefined 0x9-0xD: T2-T4 empty.
REQ-014 At most one bus driver SHALL be high in any step; all opcode/flag combinations comply.
REQ-015 With step_en high, step advances one per clk; after T4 it wraps to T0.
REQ-016 HLT: on the edge ending T2, state SHALL go to HALT; in HALT halt=1, all other outputs 0, step holds at 2; only reset exits.
REQ-017 Flags are sampled combinationally in T2; flag changes in other steps SHALL not affect outputs.
REQ-018 instruction changes outside T1/T2 SHALL only affect decode of the current step (no internal opcode latch).

Reset
REQ-019 rst_n low at a rising edge SHALL force state FETCH, step T0, regardless of step_en or HALT.
REQ-020 While in reset and on the first cycle after, outputs SHALL equal the T0 word (pc_out=1, mar_in=1, all else 0).
REQ-021 Reset asserted mid-instruction SHALL abandon it; no partial-step outputs persist.

Configuration
REQ-022 Macro SEQ_EARLY_END_EN: when defined, after any step whose remaining EXEC steps are all empty, next step SHALL be T0 (NOP/untaken JC/JZ = 3 cycles incl. T2, LDI/JMP/OUT = 3, LDA/STA = 4, ADD/SUB = 5).
REQ-023 Without SEQ_EARLY_END_EN every instruction SHALL take exactly 5 steps.

Structure
REQ-024 Shared package cpu_pkg SHALL hold opcode enum, step enum (T0-T4), state enum, control-word struct and opcode constants.
REQ-025 Sub-module microcode_rom SHALL map (opcode, step, carry, zero) to control word combinationally; instr_sequencer holds state/step and early-end logic.

Verification
REQ-026 Reset then step_en=1, instruction=0x00 -> T0 word then T1 word; without macro step 0,1,2,3,4,0; with macro step 0,1,2,0.
REQ-027 instruction=0x2A (ADD) -> T2 i_out,mar_in; T3 ram_out,b_in; T4 alu_out,a_in,flags_in, alu_sub=0; 0x3A same with alu_sub=1 in T4.
REQ-028 instruction=0x73, carry_flag=0 -> T2 no pc_jump; carry_flag=1 -> T2 i_out,pc_jump.
REQ-029 instruction=0xF0 -> T2 halt=1; then 10 cycles with step_en=1: halt=1, step=2, all else 0; rst_n=0 one edge -> T0 word.
REQ-030 instruction=0x4C, step_en toggled 1/0 each cycle -> each step held two cycles, sequence T2 i_out,mar_in; T3 a_out,ram_in.
REQ-031 Random opcodes/flags, 10k cycles -> bus-driver one-hot-or-zero assertion never fires; rst_n=0 at T3 of LDA -> next step T0.
